// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings, arbiter state encoding and burst-length helper for ahb_bus_arbiter.
package ahb_arb_pkg;

   localparam int unsigned HTRANS_W = 2;
   localparam int unsigned HBURST_W = 3;
   localparam int unsigned HSIZE_W  = 3;
   localparam int unsigned BEAT_W   = 4;

   localparam logic [HTRANS_W-1:0] IDLE   = 2'b00;
   localparam logic [HTRANS_W-1:0] BUSY   = 2'b01;
   localparam logic [HTRANS_W-1:0] NONSEQ = 2'b10;
   localparam logic [HTRANS_W-1:0] SEQ    = 2'b11;

   localparam logic [HBURST_W-1:0] SINGLE = 3'b000;
   localparam logic [HBURST_W-1:0] INCR   = 3'b001;
   localparam logic [HBURST_W-1:0] WRAP4  = 3'b010;
   localparam logic [HBURST_W-1:0] INCR4  = 3'b011;
   localparam logic [HBURST_W-1:0] WRAP8  = 3'b100;
   localparam logic [HBURST_W-1:0] INCR8  = 3'b101;
   localparam logic [HBURST_W-1:0] WRAP16 = 3'b110;
   localparam logic [HBURST_W-1:0] INCR16 = 3'b111;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BURST = 2'd1,
      ARB_INCR  = 2'd2
   } arb_state_t;

   // Address-phase control of one master, packed in port slice order.
   typedef struct packed {
      logic [HTRANS_W-1:0] trans;
      logic [HBURST_W-1:0] burst;
      logic [HSIZE_W-1:0]  size;
      logic                write;
   } ahb_ctrl_t;

   // Remaining beats after the NONSEQ beat of a burst.
   function automatic logic [BEAT_W-1:0] burst_beats(input logic [HBURST_W-1:0] burst);
      logic [BEAT_W-1:0] beats;
      case (burst)
         WRAP4, INCR4:   beats = 4'd3;
         WRAP8, INCR8:   beats = 4'd7;
         WRAP16, INCR16: beats = 4'd15;
         default:        beats = 4'd0;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Slave-side AHB bus between ahb_bus_arbiter (master modport) and the shared slave.
interface ahb_bus_arbiter_if
   import ahb_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                ahb_sel_out;
   logic [ADDR_W-1:0]   ahb_addr_out;
   logic [HTRANS_W-1:0] ahb_trans_out;
   logic [HBURST_W-1:0] ahb_burst_out;
   logic [HSIZE_W-1:0]  ahb_size_out;
   logic                ahb_write_out;
   logic [DATA_W-1:0]   ahb_wdata_out;
   logic                ahb_ready_in;
   logic                ahb_resp_in;
   logic [DATA_W-1:0]   ahb_rdata_in;

   modport master (
      output ahb_sel_out, ahb_addr_out, ahb_trans_out, ahb_burst_out,
             ahb_size_out, ahb_write_out, ahb_wdata_out,
      input  ahb_ready_in, ahb_resp_in, ahb_rdata_in
   );

   modport slave (
      input  ahb_sel_out, ahb_addr_out, ahb_trans_out, ahb_burst_out,
             ahb_size_out, ahb_write_out, ahb_wdata_out,
      output ahb_ready_in, ahb_resp_in, ahb_rdata_in
   );
endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after last_id, wrapping modulo NUM_MASTERS.
module ahb_rr_picker #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned MID_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [MID_W-1:0]       last_id,
   output logic [MID_W-1:0]       next_id_c,
   output logic                   valid_c
);
   int unsigned idx;

   always_comb begin
      next_id_c = last_id;
      valid_c   = 1'b0;
      idx       = 0;
      for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
         idx = (32'(last_id) + 32'(k)) % NUM_MASTERS;
         if (!valid_c && req[MID_W'(idx)]) begin
            valid_c   = 1'b1;
            next_id_c = MID_W'(idx);
         end
      end
   end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter sharing one slave port; grant moves only at burst-safe points.
// Optional master locking is enabled with `define AHB_ARB_LOCK_EN (adds m_lock_in).
module ahb_bus_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned AHB_ADDR_WIDTH = 32,
   parameter int unsigned AHB_DATA_WIDTH = 32,
   localparam int unsigned MID_W         = $clog2(NUM_MASTERS)
) (
   input  logic                                  ahb_clk_in,
   input  logic                                  ahb_rstn_in,
   input  logic [NUM_MASTERS-1:0]                m_req_in,
   input  logic [NUM_MASTERS*AHB_ADDR_WIDTH-1:0] m_addr_in,
   input  logic [NUM_MASTERS*HTRANS_W-1:0]       m_trans_in,
   input  logic [NUM_MASTERS*HBURST_W-1:0]       m_burst_in,
   input  logic [NUM_MASTERS*HSIZE_W-1:0]        m_size_in,
   input  logic [NUM_MASTERS-1:0]                m_write_in,
   input  logic [NUM_MASTERS*AHB_DATA_WIDTH-1:0] m_wdata_in,
`ifdef AHB_ARB_LOCK_EN
   input  logic [NUM_MASTERS-1:0]                m_lock_in,
`endif
   output logic [NUM_MASTERS-1:0]                m_grant_out,
   output logic                                  m_ready_out,
   output logic                                  m_resp_out,
   output logic [AHB_DATA_WIDTH-1:0]             m_rdata_out,
   output logic [MID_W-1:0]                      ahb_master_out,
   ahb_bus_arbiter_if.master                     ahb_slave_if
);
   logic [AHB_ADDR_WIDTH-1:0] addr_a  [NUM_MASTERS];
   logic [AHB_DATA_WIDTH-1:0] wdata_a [NUM_MASTERS];
   ahb_ctrl_t                 ctrl_a  [NUM_MASTERS];

   logic [MID_W-1:0]       grant_id;
   logic [NUM_MASTERS-1:0] grant_oh;
   logic [MID_W-1:0]       data_id;
   logic [BEAT_W-1:0]      beat_cnt;
   arb_state_t             state;

   ahb_ctrl_t        own_c;
   logic             own_req_c;
   logic             ap_c;
   logic [MID_W-1:0] pick_id_c;
   logic             pick_valid_c;

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
      assign addr_a[g]  = m_addr_in[g*AHB_ADDR_WIDTH +: AHB_ADDR_WIDTH];
      assign wdata_a[g] = m_wdata_in[g*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
      assign ctrl_a[g]  = {m_trans_in[g*HTRANS_W +: HTRANS_W],
                           m_burst_in[g*HBURST_W +: HBURST_W],
                           m_size_in[g*HSIZE_W +: HSIZE_W],
                           m_write_in[g]};
   end

   assign own_c     = ctrl_a[grant_id];
   assign own_req_c = m_req_in[grant_id];

   ahb_rr_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .MID_W       (MID_W)
   ) u_picker (
      .req       (m_req_in),
      .last_id   (grant_id),
      .next_id_c (pick_id_c),
      .valid_c   (pick_valid_c)
   );

   // Arbitration point: only where switching cannot split a fixed-length burst.
   always_comb begin
      ap_c = 1'b0;
      if (ahb_slave_if.ahb_ready_in) begin
         case (state)
            ARB_IDLE:  ap_c = (own_c.trans == IDLE) ||
                              ((own_c.trans == NONSEQ) && (own_c.burst == SINGLE));
            ARB_BURST: ap_c = (own_c.trans == SEQ) && (beat_cnt == 4'd1);
            ARB_INCR:  ap_c = !own_req_c;
            default:   ap_c = 1'b0;
         endcase
      end
`ifdef AHB_ARB_LOCK_EN
      if (m_lock_in[grant_id]) ap_c = 1'b0;
`endif
   end

   always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
      if (!ahb_rstn_in) begin
         grant_id <= '0;
         grant_oh <= NUM_MASTERS'(1);
         data_id  <= '0;
         beat_cnt <= '0;
         state    <= ARB_IDLE;
      end else if (ahb_slave_if.ahb_ready_in) begin
         data_id <= grant_id;
         if (ap_c && pick_valid_c && (pick_id_c != grant_id)) begin
            // New owner starts from a clean burst tracker.
            grant_id <= pick_id_c;
            grant_oh <= NUM_MASTERS'(1) << pick_id_c;
            beat_cnt <= '0;
            state    <= ARB_IDLE;
         end else begin
            case (own_c.trans)
               NONSEQ: begin
                  beat_cnt <= burst_beats(own_c.burst);
                  if (own_c.burst == SINGLE)    state <= ARB_IDLE;
                  else if (own_c.burst == INCR) state <= ARB_INCR;
                  else                          state <= ARB_BURST;
               end
               SEQ: begin
                  if (beat_cnt != '0) beat_cnt <= beat_cnt - 4'd1;
                  if ((state == ARB_BURST) && (beat_cnt <= 4'd1)) state <= ARB_IDLE;
               end
               default: begin
                  if ((own_c.trans == IDLE) && (state == ARB_INCR)) state <= ARB_IDLE;
               end
            endcase
         end
      end else if (ahb_slave_if.ahb_resp_in) begin
         // First ERROR cycle: abandon the burst so the next ready cycle re-arbitrates.
         beat_cnt <= '0;
         state    <= ARB_IDLE;
      end
   end

   assign m_grant_out    = grant_oh;
   assign ahb_master_out = grant_id;
   assign m_ready_out    = ahb_slave_if.ahb_ready_in;
   assign m_resp_out     = ahb_slave_if.ahb_resp_in;
   assign m_rdata_out    = ahb_slave_if.ahb_rdata_in;

   // Address phase forced to IDLE while reset is asserted.
   assign ahb_slave_if.ahb_addr_out  = addr_a[grant_id];
   assign ahb_slave_if.ahb_trans_out = ahb_rstn_in ? own_c.trans : IDLE;
   assign ahb_slave_if.ahb_sel_out   = ahb_rstn_in && (own_c.trans != IDLE);
   assign ahb_slave_if.ahb_burst_out = own_c.burst;
   assign ahb_slave_if.ahb_size_out  = own_c.size;
   assign ahb_slave_if.ahb_write_out = own_c.write;
   assign ahb_slave_if.ahb_wdata_out = wdata_a[data_id];

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter (4 masters, 32-bit address/data).
module tb_ahb_bus_arbiter;
   import ahb_arb_pkg::*;

   localparam int unsigned NM = 4;
   localparam logic [31:0] WD = 32'hDA7A_0000;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  m_req;
   logic [31:0] addr_a  [NM];
   logic [1:0]  trans_a [NM];
   logic [2:0]  burst_a [NM];
   logic [127:0] m_addr;
   logic [127:0] m_wdata;
   logic [7:0]   m_trans;
   logic [11:0]  m_burst;
   logic [11:0]  m_size;
   logic [3:0]   m_write;
`ifdef AHB_ARB_LOCK_EN
   logic [3:0]   m_lock;
`endif
   logic [3:0]   m_grant;
   logic         m_ready;
   logic         m_resp;
   logic [31:0]  m_rdata;
   logic [1:0]   m_master;

   int n_checks = 0;
   int n_fail   = 0;

   ahb_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) slv_if ();

   for (genvar g = 0; g < NM; g++) begin : g_pack
      assign m_addr[g*32 +: 32]  = addr_a[g];
      assign m_wdata[g*32 +: 32] = WD + 32'(g);
      assign m_trans[g*2 +: 2]   = trans_a[g];
      assign m_burst[g*3 +: 3]   = burst_a[g];
      assign m_size[g*3 +: 3]    = 3'b010;
      assign m_write[g]          = 1'b1;
   end

   ahb_bus_arbiter #(
      .NUM_MASTERS    (NM),
      .AHB_ADDR_WIDTH (32),
      .AHB_DATA_WIDTH (32)
   ) dut (
      .ahb_clk_in     (clk),
      .ahb_rstn_in    (rstn),
      .m_req_in       (m_req),
      .m_addr_in      (m_addr),
      .m_trans_in     (m_trans),
      .m_burst_in     (m_burst),
      .m_size_in      (m_size),
      .m_write_in     (m_write),
      .m_wdata_in     (m_wdata),
`ifdef AHB_ARB_LOCK_EN
      .m_lock_in      (m_lock),
`endif
      .m_grant_out    (m_grant),
      .m_ready_out    (m_ready),
      .m_resp_out     (m_resp),
      .m_rdata_out    (m_rdata),
      .ahb_master_out (m_master),
      .ahb_slave_if   (slv_if)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [1:0] i, input logic r, input logic [1:0] t,
                      input logic [2:0] b, input logic [31:0] a);
      m_req[i]   = r;
      trans_a[i] = t;
      burst_a[i] = b;
      addr_a[i]  = a;
   endtask

   task automatic idle_all();
      for (int i = 0; i < int'(NM); i++) drv(2'(i), 1'b0, IDLE, SINGLE, 32'h0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_all();
`ifdef AHB_ARB_LOCK_EN
      m_lock = 4'b0000;
`endif
      slv_if.ahb_ready_in = 1'b1;
      slv_if.ahb_resp_in  = 1'b0;
      cyc();
      rstn = 1'b1;
   endtask

   task automatic chk_grant(input string tag, input int g);
      check_val(tag, 32'(m_grant), 32'(1) << g);
   endtask

   initial begin
      rstn = 1'b0;
      m_req = 4'b0000;
      idle_all();
`ifdef AHB_ARB_LOCK_EN
      m_lock = 4'b0000;
`endif
      slv_if.ahb_ready_in = 1'b1;
      slv_if.ahb_resp_in  = 1'b0;
      slv_if.ahb_rdata_in = 32'h0;
      // Master 0 drives NONSEQ during reset: output must still be IDLE.
      drv(2'd0, 1'b0, NONSEQ, SINGLE, 32'h0000_1000);
      repeat (2) cyc();
      check_val("rst_grant", 32'(m_grant), 32'h1);
      check_val("rst_master", 32'(m_master), 32'h0);
      check_val("rst_trans", 32'(slv_if.ahb_trans_out), 32'(IDLE));
      check_val("rst_sel", 32'(slv_if.ahb_sel_out), 32'h0);
      slv_if.ahb_ready_in = 1'b0;
      slv_if.ahb_resp_in  = 1'b1;
      slv_if.ahb_rdata_in = 32'h1234_5678;
      #1;
      check_val("pass_ready_lo", 32'(m_ready), 32'h0);
      check_val("pass_resp_hi", 32'(m_resp), 32'h1);
      check_val("pass_rdata", m_rdata, 32'h1234_5678);
      slv_if.ahb_ready_in = 1'b1;
      slv_if.ahb_resp_in  = 1'b0;
      #1;
      check_val("pass_ready_hi", 32'(m_ready), 32'h1);

      // Masters 0 and 2 doing SINGLE writes: grant alternates, wdata one cycle behind.
      do_reset();
      drv(2'd0, 1'b1, NONSEQ, SINGLE, 32'h0000_1000);
      drv(2'd2, 1'b1, NONSEQ, SINGLE, 32'h0000_2000);
      for (int k = 0; k < 4; k++) begin
         int g;
         int d;
         g = (k % 2 == 1) ? 2 : 0;
         d = (k == 0) ? 0 : (((k - 1) % 2 == 1) ? 2 : 0);
         #1;
         chk_grant($sformatf("alt_grant%0d", k), g);
         check_val($sformatf("alt_master%0d", k), 32'(m_master), 32'(g));
         check_val($sformatf("alt_addr%0d", k), slv_if.ahb_addr_out, (g == 2) ? 32'h2000 : 32'h1000);
         check_val($sformatf("alt_wdata%0d", k), slv_if.ahb_wdata_out, WD + 32'(d));
         check_val($sformatf("alt_sel%0d", k), 32'(slv_if.ahb_sel_out), 32'h1);
         cyc();
      end

      // INCR4 on master 1 is not split by master 3 requesting mid-burst.
      do_reset();
      drv(2'd1, 1'b1, NONSEQ, INCR4, 32'h100);
      #1; chk_grant("i4_pre", 0); cyc();
      #1; chk_grant("i4_b1", 1);
      check_val("i4_a1", slv_if.ahb_addr_out, 32'h100);
      check_val("i4_t1", 32'(slv_if.ahb_trans_out), 32'(NONSEQ));
      cyc();
      drv(2'd3, 1'b1, NONSEQ, SINGLE, 32'h3000);
      for (int b = 1; b < 4; b++) begin
         drv(2'd1, 1'b1, SEQ, INCR4, 32'h100 + 32'(4 * b));
         #1;
         chk_grant($sformatf("i4_b%0d", b + 1), 1);
         check_val($sformatf("i4_a%0d", b + 1), slv_if.ahb_addr_out, 32'h100 + 32'(4 * b));
         cyc();
      end
      drv(2'd1, 1'b0, IDLE, SINGLE, 32'h0);
      #1;
      chk_grant("i4_next", 3);
      check_val("i4_next_master", 32'(m_master), 32'h3);
      check_val("i4_next_addr", slv_if.ahb_addr_out, 32'h3000);
      check_val("i4_last_wdata", slv_if.ahb_wdata_out, WD + 32'h1);
      cyc();

      // INCR8 with a three-cycle wait state at beat 5: no early release.
      do_reset();
      drv(2'd0, 1'b1, IDLE, SINGLE, 32'h0);
      drv(2'd1, 1'b1, NONSEQ, INCR8, 32'h200);
      #1; chk_grant("i8_pre", 0); cyc();
      for (int b = 1; b <= 8; b++) begin
         drv(2'd1, 1'b1, (b == 1) ? NONSEQ : SEQ, INCR8, 32'h200 + 32'(4 * (b - 1)));
         if (b == 5) begin
            slv_if.ahb_ready_in = 1'b0;
            for (int s = 0; s < 3; s++) begin
               #1;
               chk_grant($sformatf("i8_wait%0d", s), 1);
               check_val($sformatf("i8_rdy%0d", s), 32'(m_ready), 32'h0);
               cyc();
            end
            slv_if.ahb_ready_in = 1'b1;
         end
         #1;
         chk_grant($sformatf("i8_b%0d", b), 1);
         cyc();
      end
      drv(2'd1, 1'b0, IDLE, SINGLE, 32'h0);
      #1;
      chk_grant("i8_next", 0);
      check_val("i8_last_wdata", slv_if.ahb_wdata_out, WD + 32'h1);
      cyc();

      // Undefined-length INCR: release at first ready cycle after request drops.
      do_reset();
      drv(2'd0, 1'b1, NONSEQ, INCR, 32'h300);
      drv(2'd1, 1'b1, NONSEQ, SINGLE, 32'h3100);
      for (int b = 0; b < 6; b++) begin
         if (b > 0) drv(2'd0, 1'b1, SEQ, INCR, 32'h300 + 32'(4 * b));
         #1;
         chk_grant($sformatf("incr_b%0d", b), 0);
         cyc();
      end
      drv(2'd0, 1'b0, IDLE, SINGLE, 32'h0);
      slv_if.ahb_ready_in = 1'b0;
      #1; chk_grant("incr_drop_wait", 0); cyc();
      slv_if.ahb_ready_in = 1'b1;
      #1; chk_grant("incr_drop_rdy", 0); cyc();
      #1;
      chk_grant("incr_next", 1);
      check_val("incr_next_addr", slv_if.ahb_addr_out, 32'h3100);
      cyc();

      // Two-cycle ERROR during WRAP16 ends the burst; pending master 3 wins.
      do_reset();
      drv(2'd2, 1'b1, NONSEQ, WRAP16, 32'h400);
      drv(2'd3, 1'b1, NONSEQ, SINGLE, 32'h3300);
      #1; chk_grant("w16_pre", 0); cyc();
      for (int b = 1; b <= 3; b++) begin
         drv(2'd2, 1'b1, (b == 1) ? NONSEQ : SEQ, WRAP16, 32'h400 + 32'(4 * (b - 1)));
         #1;
         chk_grant($sformatf("w16_b%0d", b), 2);
         cyc();
      end
      drv(2'd2, 1'b1, SEQ, WRAP16, 32'h40C);
      slv_if.ahb_ready_in = 1'b0;
      slv_if.ahb_resp_in  = 1'b1;
      #1;
      chk_grant("w16_err1", 2);
      check_val("w16_resp", 32'(m_resp), 32'h1);
      cyc();
      drv(2'd2, 1'b1, IDLE, SINGLE, 32'h0);
      slv_if.ahb_ready_in = 1'b1;
      #1; chk_grant("w16_err2", 2); cyc();
      slv_if.ahb_resp_in = 1'b0;
      drv(2'd2, 1'b0, IDLE, SINGLE, 32'h0);
      #1;
      chk_grant("w16_next", 3);
      check_val("w16_next_addr", slv_if.ahb_addr_out, 32'h3300);
      cyc();

      // Asynchronous reset in the middle of an INCR8.
      do_reset();
      drv(2'd1, 1'b1, NONSEQ, INCR8, 32'h600);
      #1; chk_grant("rmid_pre", 0); cyc();
      for (int b = 1; b <= 3; b++) begin
         drv(2'd1, 1'b1, (b == 1) ? NONSEQ : SEQ, INCR8, 32'h600 + 32'(4 * (b - 1)));
         #1; chk_grant($sformatf("rmid_b%0d", b), 1); cyc();
      end
      drv(2'd1, 1'b1, SEQ, INCR8, 32'h60C);
      drv(2'd0, 1'b0, NONSEQ, SINGLE, 32'hBAD0);
      #1; chk_grant("rmid_b4", 1);
      rstn = 1'b0;
      #1;
      chk_grant("rmid_grant", 0);
      check_val("rmid_master", 32'(m_master), 32'h0);
      check_val("rmid_trans", 32'(slv_if.ahb_trans_out), 32'(IDLE));
      check_val("rmid_sel", 32'(slv_if.ahb_sel_out), 32'h0);
      cyc();
      rstn = 1'b1;
      drv(2'd0, 1'b0, IDLE, SINGLE, 32'h0);
      drv(2'd1, 1'b1, NONSEQ, INCR8, 32'h600);
      #1; chk_grant("rmid_after0", 0); cyc();
      #1; chk_grant("rmid_after1", 1); cyc();

`ifdef AHB_ARB_LOCK_EN
      // Locked master 1 keeps the bus across two INCR4 bursts.
      do_reset();
      m_lock = 4'b0010;
      drv(2'd0, 1'b1, IDLE, SINGLE, 32'h0);
      drv(2'd1, 1'b1, NONSEQ, INCR4, 32'h500);
      #1; chk_grant("lk_pre", 0); cyc();
      for (int n = 0; n < 2; n++) begin
         for (int b = 0; b < 4; b++) begin
            drv(2'd1, 1'b1, (b == 0) ? NONSEQ : SEQ, INCR4, 32'h500 + 32'(16 * n + 4 * b));
            #1; chk_grant($sformatf("lk_n%0d_b%0d", n, b), 1); cyc();
         end
      end
      m_lock = 4'b0000;
      drv(2'd1, 1'b0, IDLE, SINGLE, 32'h0);
      #1; chk_grant("lk_release", 1); cyc();
      #1; chk_grant("lk_next", 0); cyc();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
